rv32c_fetch_queue: RTL
======================

# rv32c_fetch_queue

Parametrised RV32C fetch queue between the instruction-memory port and decode. Holds a configurable number of 16-bit parcels in a circular buffer and prefetches aligned words while space remains. Presents one aligned 16- or 32-bit instruction per cycle under a valid/ready handshake, and handles misaligned redirects and in-flight fetch cancellation.

## Interface
- DEPTH_HW, 8, parcel (halfword) capacity; power of two, ≥4
- RESET_PC, 32'h0000_0200, fetch PC after reset; bit 0 must be 0
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- redirect_en  in  1  flush and restart fetch at redirect_pc (branch/jump/trap)
- redirect_pc  in  32  new PC; bit 1 may be set, bit 0 ignored
- imem_req  out  1  word fetch request; held until imem_ack
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1
- imem_ack  in  1  one-cycle pulse: imem_rdata valid, request complete
- imem_rdata  in  32  fetched word; bits [15:0] at imem_addr, [31:16] at +2
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decode accepts
- inst  out  32  instruction; compressed parcels zero-extended to 32 bits
- inst_pc  out  32  PC of inst
- inst_compressed  out  1  inst[1:0] != 2'b11

## Operation
- Parcel buffer: rd/wr pointers wrap modulo DEPTH_HW; count width $clog2(DEPTH_HW+1).
- Head decode: head[1:0]!=11 → 16-bit; valid when count≥1. Else 32-bit; valid when count≥2; inst={parcel[rd+1],parcel[rd]}.
- Handshake: valid&ready pops 1 or 2 parcels; head PC advances by 2 or 4. inst_valid never depends on inst_ready.
- Push: on imem_ack (not discarded), push 2 parcels, or only [31:16] if skip_lo is set; skip_lo then clears.
- Fetch FSM (imem_req = state!=IDLE):
  - IDLE: if free≥2 after this cycle's pop, go to WAIT.
  - WAIT: on ack, imem_addr+=4. Stay in WAIT if free≥2 after push/pop, else go to IDLE.
  - DRAIN: request in flight after a redirect. Address is held. On ack, discard data, load target address, go to WAIT.
- Redirect (priority over push/pop in same cycle):
  - Flush count/pointers.
  - head PC=redirect_pc.
  - skip_lo=redirect_pc[1].
  - target={redirect_pc[31:2],2'b00}.
  - IDLE→WAIT with target.
  - WAIT without ack→DRAIN.
  - WAIT with ack→data discarded, WAIT with target.
  - DRAIN→DRAIN with the target updated.
- Full: no request is issued while free<2. An outstanding word always has space reserved.
- Empty or partial 32-bit head: inst_valid=0. Upper parcel waits for next word (straddling instruction).

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC&~3, inst_valid=0, inst=0, inst_pc=RESET_PC, inst_compressed=0, state IDLE, skip_lo=0.
- First request is asserted the cycle after reset release.
- Ack-to-inst_valid latency: 1 cycle (data registered in buffer), unless bypass is enabled.
- Sustained throughput: one word per cycle while ack returns each cycle and space remains.
- Redirect: inst_valid=0 from the cycle after redirect_en until the first useful word is pushed.
- Reset mid-request: outstanding request abandoned. The memory side is reset with the same n_rst.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count==0 and imem_ack delivers a complete head instruction, the instruction is presented combinationally in the same cycle. A complete head is a compressed low parcel, an aligned 32-bit word, or a compressed upper parcel with skip_lo. Accepted parcels are not written; leftovers are written.
- Undefined: all data goes through the buffer; latency is fixed at 1 cycle.

## Structure
- Package rv32c_pkg:
  - fetch_state_t enum {IDLE, WAIT, DRAIN}
  - parcel_t (logic [15:0])
  - function is_compressed(parcel_t)
  - RV32C_ILEN16/ILEN32 constants
- Sub-module rv32c_parcel_fifo: circular buffer with 0/1/2-parcel push, 0/1/2-parcel pop, flush, count, and head/head+1 outputs.

## Test plan
- Aligned stream: RESET_PC=0x200; words 0x00000013, 0x00A00093; inst_ready=1 → inst 0x00000013 @0x200, then 0x00A00093 @0x204, inst_compressed=0.
- Mixed: word 0x0001_4501 then 0x0000_0013:
  - c.li a0,0 @0x200 (inst=0x00004501)
  - c.nop @0x202 (0x00000001)
  - 32-bit @0x204
- Straddle: word 0x0093_4501 then 0x0000_00A0 → 0x4501 @0x200, then 0x00A00093 @0x202, valid only after second ack.
- Misaligned redirect to 0x302 while a request is outstanding:
  - FSM enters DRAIN; old ack data discarded.
  - imem_addr=0x300; upper parcel of the new word only pushed.
  - First inst_pc=0x302.
- Full/backpressure: DEPTH_HW=4, inst_ready=0 → exactly 2 words fetched, imem_req=0 afterwards. Releasing ready resumes fetch with no parcel lost.
- Bypass (macro defined): empty queue, ack with 0x00000013, ready=1 → inst_valid=1 in the ack cycle, count stays 0.

Source files
------------

// File: rtl/rv32c_pkg.sv
// Shared types and helpers for the RV32C fetch queue.
package rv32c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef logic [15:0] parcel_t;

    localparam int RV32C_ILEN16 = 16;
    localparam int RV32C_ILEN32 = 32;

    // A parcel starts a 16-bit instruction unless its low two bits are 11.
    function automatic logic is_compressed(input parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/rv32c_parcel_fifo.sv
// Circular buffer of 16-bit parcels: pushes and pops of 0, 1 or 2 parcels
// per cycle, synchronous flush, and the two head parcels exposed for decode.
module rv32c_parcel_fifo
    import rv32c_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_flush,
    input  logic [1:0]    i_push_n,
    input  parcel_t       i_push_d0,
    input  parcel_t       i_push_d1,
    input  logic [1:0]    i_pop_n,
    output logic [CW-1:0] o_count,
    output parcel_t       o_head0,
    output parcel_t       o_head1
);

    parcel_t         r_mem [DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;

    // Parcel storage: d0 lands at the write pointer, d1 right after it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (!i_flush) begin
            if (i_push_n != 2'd0) r_mem[r_wr] <= i_push_d0;
            if (i_push_n == 2'd2) r_mem[r_wr + PW'(1)] <= i_push_d1;
        end
    end

    // Pointer and occupancy update; power-of-two depth makes wrap implicit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + PW'(i_push_n);
            r_rd    <= r_rd + PW'(i_pop_n);
            r_count <= r_count + CW'(i_push_n) - CW'(i_pop_n);
        end
    end

    assign o_count = r_count;
    assign o_head0 = r_mem[r_rd];
    assign o_head1 = r_mem[r_rd + PW'(1)];

endmodule

// File: rtl/rv32c_fetch_queue.sv
// RV32C fetch queue: prefetches aligned words into a parcel buffer and hands
// decode one 16/32-bit instruction per cycle, with redirect and drain of an
// in-flight fetch.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue presents a complete
// head instruction straight from imem_rdata in the ack cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request; waits for two free parcel slots
// WAIT  | request at r_addr outstanding; ack data is pushed
// DRAIN | stale request outstanding after redirect; ack data is dropped
module rv32c_fetch_queue
    import rv32c_pkg::*;
#(
    parameter int          DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_redirect_en,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_compressed
);

    localparam int          CW      = $clog2(DEPTH_HW + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH_HW);

    fetch_state_t  r_state;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [31:0]   r_target;
    logic [31:0]   r_pc;
    logic          r_skip_lo;

    logic [CW-1:0] w_count;
    parcel_t       w_h0;
    parcel_t       w_h1;
    parcel_t       w_lo;
    parcel_t       w_hi;
    logic          w_ack_use;
    logic          w_buf_c;
    logic          w_buf_valid;
    logic          w_inst_valid;
    logic          w_inst_c;
    logic [31:0]   w_inst_raw;
    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_n;
    parcel_t       w_push_d0;
    parcel_t       w_push_d1;
    logic [CW:0]   w_free_after;
    logic [31:0]   w_target;

    assign w_lo      = i_imem_rdata[15:0];
    assign w_hi      = i_imem_rdata[31:16];
    assign w_ack_use = i_imem_ack && (r_state == WAIT) && !i_redirect_en;
    assign w_target  = {i_redirect_pc[31:2], 2'b00};

    rv32c_parcel_fifo #(.DEPTH(DEPTH_HW)) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_flush   (i_redirect_en),
        .i_push_n  (w_push_n),
        .i_push_d0 (w_push_d0),
        .i_push_d1 (w_push_d1),
        .i_pop_n   (w_pop_n),
        .o_count   (w_count),
        .o_head0   (w_h0),
        .o_head1   (w_h1)
    );

    assign w_buf_c     = is_compressed(w_h0);
    assign w_buf_valid = w_buf_c ? (w_count != '0) : (w_count > CW'(1));

    // Select the presented instruction and work out how many parcels move.
    always_comb begin
        w_inst_valid = w_buf_valid;
        w_inst_c     = w_buf_c;
        w_inst_raw   = w_buf_c ? {16'h0000, w_h0} : {w_h1, w_h0};
        w_push_n     = 2'd0;
        w_push_d0    = w_lo;
        w_push_d1    = w_hi;
        w_pop_n      = 2'd0;
        if (w_ack_use) begin
            if (r_skip_lo) begin
                w_push_n  = 2'd1;
                w_push_d0 = w_hi;
            end else begin
                w_push_n  = 2'd2;
            end
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        // Buffer is empty, so head parcels come straight from the bus; only
        // parcels not consumed by decode this cycle are written.
        if (w_ack_use && (w_count == '0)) begin
            if (r_skip_lo) begin
                if (is_compressed(w_hi)) begin
                    w_inst_valid = 1'b1;
                    w_inst_c     = 1'b1;
                    w_inst_raw   = {16'h0000, w_hi};
                    if (i_inst_ready) w_push_n = 2'd0;
                end
            end else if (is_compressed(w_lo)) begin
                w_inst_valid = 1'b1;
                w_inst_c     = 1'b1;
                w_inst_raw   = {16'h0000, w_lo};
                if (i_inst_ready) begin
                    w_push_n  = 2'd1;
                    w_push_d0 = w_hi;
                end
            end else begin
                w_inst_valid = 1'b1;
                w_inst_c     = 1'b0;
                w_inst_raw   = i_imem_rdata;
                if (i_inst_ready) w_push_n = 2'd0;
            end
        end
`endif
        if (w_buf_valid && i_inst_ready) w_pop_n = w_buf_c ? 2'd1 : 2'd2;
    end

    // Free slots once this cycle's push and pop have been applied.
    assign w_free_after = DEPTH_W - {1'b0, w_count}
                        + (CW + 1)'(w_pop_n) - (CW + 1)'(w_push_n);

    // Fetch FSM, head PC and skip_lo; redirect overrides everything else.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_addr    <= RESET_PC & ~32'h3;
            r_target  <= RESET_PC & ~32'h3;
            r_pc      <= RESET_PC;
            r_skip_lo <= 1'b0;
        end else if (i_redirect_en) begin
            r_pc      <= i_redirect_pc & ~32'h1;
            r_skip_lo <= i_redirect_pc[1];
            r_target  <= w_target;
            case (r_state)
                IDLE: begin
                    r_state <= WAIT;
                    r_req   <= 1'b1;
                    r_addr  <= w_target;
                end
                WAIT: begin
                    if (i_imem_ack) begin
                        r_addr <= w_target;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The stale request completing now lets the new one start.
                    if (i_imem_ack) begin
                        r_state <= WAIT;
                        r_addr  <= w_target;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end else begin
            if (w_inst_valid && i_inst_ready)
                r_pc <= r_pc + (w_inst_c ? 32'd2 : 32'd4);
            case (r_state)
                IDLE: begin
                    if (w_free_after >= (CW + 1)'(2)) begin
                        r_state <= WAIT;
                        r_req   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (i_imem_ack) begin
                        r_addr    <= r_addr + 32'd4;
                        r_skip_lo <= 1'b0;
                        if (w_free_after < (CW + 1)'(2)) begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (i_imem_ack) begin
                        r_state <= WAIT;
                        r_addr  <= r_target;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req        = r_req;
    assign o_imem_addr       = r_addr;
    assign o_inst_valid      = w_inst_valid;
    assign o_inst            = w_inst_valid ? w_inst_raw : 32'h0;
    assign o_inst_pc         = r_pc;
    assign o_inst_compressed = w_inst_valid && w_inst_c;

endmodule
